control_pipeline: RTL and testbench
===================================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter HALT_OP, default 4'hF, meaning the opcode that starts pipeline drain and halt.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles from HALT decode to halted assertion.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, the reset; asynchronous, active-high.
REQ-005 SHALL have port instruction_IF, input, 16, the instruction in ID; opcode = [15:12].
REQ-006 SHALL have port stall, input, 1, the load-use stall from hazard detection.
REQ-007 SHALL have port flush, input, 1, the control-hazard flush.
REQ-008 SHALL have port opcode, output, 4, the ID opcode to ALU/EX register; 4'hE (NOP) when suppressed.
REQ-009 SHALL have ports ImmSrc (output, 2), ALUsrc, dir, is_unsigned, Branch, jump, PC_sel (output, 1 each), the combinational ID controls.
REQ-010 SHALL have ports MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM, output, 1 each, the MEM-stage registered controls.
REQ-011 SHALL have port RegWrite_WB, output, 1, the WB-stage registered write enable.
REQ-012 SHALL have port halted, output, 1, high once the drain completes.
REQ-013 SHALL have port state, output, 2, the FSM state for debug: 0 RUN, 1 DRAIN, 2 HALTED.

Function
REQ-014 SHALL decode the opcode map 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SHIFT, 7 ADDI, 8 LW, 9 SW, A BEQ, B BNE, C JMP, D SLTU, E NOP, F HALT.
REQ-015 SHALL drive ALUsrc=1 for ADDI/LW/SW, and 0 otherwise.
REQ-016 SHALL drive ImmSrc: 00 for ADDI/LW (instr[5:0]), 01 for SW (instr[11:9],instr[2:0]), 10 for BEQ/BNE/JMP (instr[7:0]), 11 otherwise.
REQ-017 SHALL drive dir=instr[0] for SHIFT, else 0; is_unsigned=1 only for SLTU.
REQ-018 SHALL drive Branch=1 for BEQ/BNE, jump=1 for JMP, and PC_sel=Branch|jump.
REQ-019 SHALL derive ID-level write controls: RegWrite for ops 0-8 and D; MemRead and ResultSrc for LW; MemWrite for SW.
REQ-020 SHALL suppress decode when flush=1 or state!=RUN: all ID outputs 0, opcode=4'hE.
REQ-021 SHALL update the ID->EX control register each edge: bubble (all 0) if stall or flush, else load the ID-level write controls.
REQ-022 SHALL load the EX->MEM register unconditionally from the ID->EX register each edge; stall does not freeze it.
REQ-023 SHALL load the MEM->WB register (RegWrite) from RegWrite_MEM each edge.
REQ-024 SHALL give a latency of ID decode in cycle N -> *_MEM outputs in cycle N+2 -> RegWrite_WB in cycle N+3.
REQ-025 SHALL transition FSM RUN->DRAIN when opcode==HALT_OP with flush=0 and stall=0; HALT under stall waits until stall drops.
REQ-026 SHALL load a drain counter with DRAIN_CYCLES on entry to DRAIN and decrement it each cycle; when it reaches 0, go DRAIN->HALTED.
REQ-027 SHALL treat HALTED as terminal; only reset leaves it; halted=1 in HALTED only.
REQ-028 SHALL ignore flush in DRAIN and HALTED; instructions already in flight still complete.
REQ-029 SHALL have HALT itself carry no write controls, which enter the pipe as a bubble.

Reset
REQ-030 SHALL, on reset, clear all pipeline control registers, the counter, and halted to 0 and set state=RUN asynchronously.
REQ-031 SHALL, on reset asserted mid-DRAIN or in HALTED, return to RUN immediately with *_MEM=0 and RegWrite_WB=0.

Verification
REQ-032 SHALL check: LW 0x8xxx at cycle 0 -> MemRead_MEM=ResultSrc_MEM=RegWrite_MEM=1 at cycle 2; RegWrite_WB=1 at cycle 3.
REQ-033 SHALL check: SW with stall=1 at cycle 0 -> MemWrite_MEM=0 at cycle 2; same SW retried with stall=0 at cycle 1 -> MemWrite_MEM=1 at cycle 3.
REQ-034 SHALL check: BEQ 0xA0F0 -> Branch=1, PC_sel=1, ImmSrc=10 combinationally; flush=1 same cycle -> all 0, opcode=E.
REQ-035 SHALL check: ADD at cycle 0, HALT at cycle 1 -> state=DRAIN at cycle 2, RegWrite_WB=1 at cycle 3, halted=1 at cycle 5, later instructions give opcode=E.
REQ-036 SHALL check: HALT with flush=1 -> state stays RUN, halted=0.
REQ-037 SHALL check: reset pulse while halted=1 -> halted=0, state=0 without a clock edge; next ADD decodes normally.

Source files
------------

// File: rtl/control_pipeline.sv
// ID-stage decoder with ID->EX->MEM->WB control registers and a halt/drain FSM.
// Latency: decode in N gives *_MEM in N+2 and RegWrite_WB in N+3; stall or flush bubbles only the ID->EX register.
module control_pipeline #(
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter int         DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction_IF,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  opcode,
    output logic [1:0]  ImmSrc,
    output logic        ALUsrc,
    output logic        dir,
    output logic        is_unsigned,
    output logic        Branch,
    output logic        jump,
    output logic        PC_sel,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        RegWrite_MEM,
    output logic        ResultSrc_MEM,
    output logic        RegWrite_WB,
    output logic        halted,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] OP_SHIFT = 4'h6;
    localparam logic [3:0] OP_ADDI  = 4'h7;
    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_SW    = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_SLTU  = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;

    localparam int              CNT_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic result_src;
    } wctl_t;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    wctl_t            idex_q, idex_d;
    wctl_t            exmem_q, exmem_d;
    logic             wb_q, wb_d;

    logic [3:0] raw_op;
    logic       id_active;
    wctl_t      id_wctl;

    assign raw_op    = instruction_IF[15:12];
    assign id_active = !flush && (state_q == ST_RUN);

    // Combinational ID decode; everything collapses to a NOP when suppressed.
    always_comb begin
        opcode      = OP_NOP;
        ImmSrc      = 2'b00;
        ALUsrc      = 1'b0;
        dir         = 1'b0;
        is_unsigned = 1'b0;
        Branch      = 1'b0;
        jump        = 1'b0;
        PC_sel      = 1'b0;
        id_wctl     = '0;
        if (id_active) begin
            opcode = raw_op;
            ImmSrc = 2'b11;
            case (raw_op)
                OP_ADDI, OP_LW: begin
                    ALUsrc = 1'b1;
                    ImmSrc = 2'b00;
                end
                OP_SW: begin
                    ALUsrc = 1'b1;
                    ImmSrc = 2'b01;
                end
                OP_BEQ, OP_BNE: begin
                    Branch = 1'b1;
                    ImmSrc = 2'b10;
                end
                OP_JMP: begin
                    jump   = 1'b1;
                    ImmSrc = 2'b10;
                end
                OP_SHIFT: dir         = instruction_IF[0];
                OP_SLTU:  is_unsigned = 1'b1;
                default:  ImmSrc      = 2'b11;
            endcase
            PC_sel             = Branch | jump;
            id_wctl.reg_write  = (raw_op <= OP_LW) || (raw_op == OP_SLTU);
            id_wctl.mem_read   = (raw_op == OP_LW);
            id_wctl.result_src = (raw_op == OP_LW);
            id_wctl.mem_write  = (raw_op == OP_SW);
            // HALT enters the pipe as a bubble whatever opcode it is mapped to.
            if (raw_op == HALT_OP) begin
                id_wctl = '0;
            end
        end
    end

    always_comb begin
        idex_d  = (stall || flush) ? wctl_t'('0) : id_wctl;
        exmem_d = idex_q;
        wb_d    = exmem_q.reg_write;
    end

    // DRAIN lasts DRAIN_CYCLES cycles, then HALTED holds until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if ((raw_op == HALT_OP) && !flush && !stall) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            idex_q   <= '0;
            exmem_q  <= '0;
            wb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            idex_q   <= idex_d;
            exmem_q  <= exmem_d;
            wb_q     <= wb_d;
        end
    end

    assign MemRead_MEM   = exmem_q.mem_read;
    assign MemWrite_MEM  = exmem_q.mem_write;
    assign RegWrite_MEM  = exmem_q.reg_write;
    assign ResultSrc_MEM = exmem_q.result_src;
    assign RegWrite_WB   = wb_q;
    assign halted        = halted_q;
    assign state         = state_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: directed scenarios plus random instruction streams against a cycle-indexed model.
module tb_control_pipeline;

    localparam int          DC  = 3;
    localparam logic [15:0] NOP = 16'hE000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction_IF;
    logic        stall, flush;
    logic [3:0]  opcode;
    logic [1:0]  ImmSrc;
    logic        ALUsrc, dir, is_unsigned, Branch, jump, PC_sel;
    logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM;
    logic        RegWrite_WB, halted;
    logic [1:0]  state;

    control_pipeline #(.HALT_OP(4'hF), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .instruction_IF(instruction_IF),
        .stall(stall), .flush(flush), .opcode(opcode), .ImmSrc(ImmSrc),
        .ALUsrc(ALUsrc), .dir(dir), .is_unsigned(is_unsigned), .Branch(Branch),
        .jump(jump), .PC_sel(PC_sel), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .RegWrite_MEM(RegWrite_MEM),
        .ResultSrc_MEM(ResultSrc_MEM), .RegWrite_WB(RegWrite_WB),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: cycle count since reset, cycle of the accepted HALT, and the
    // write-control word ({mem_read, mem_write, reg_write, result_src}) each cycle pushed into the pipe.
    int         cyc;
    int         halt_at;
    logic [3:0] hist[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_state(input int c);
        if (halt_at < 0 || c <= halt_at) return 0;
        if (c - halt_at <= DC) return 1;
        return 2;
    endfunction

    task automatic step(input logic [15:0] ins, input logic st, input logic fl);
        int         es;
        logic       active;
        logic [3:0] op, op_exp;
        logic [1:0] imm;
        logic       alus, dirx, uns, br, jp;
        logic [3:0] wc, mem_exp;
        logic       wb_exp;
        instruction_IF = ins;
        stall          = st;
        flush          = fl;
        #1;
        es     = exp_state(cyc);
        active = !fl && (es == 0);
        op     = ins[15:12];
        op_exp = 4'hE;
        imm    = 2'b00;
        alus   = 1'b0; dirx = 1'b0; uns = 1'b0; br = 1'b0; jp = 1'b0;
        wc     = 4'b0000;
        if (active) begin
            op_exp = op;
            alus   = op inside {4'h7, 4'h8, 4'h9};
            if (op == 4'h7 || op == 4'h8)    imm = 2'b00;
            else if (op == 4'h9)             imm = 2'b01;
            else if (op inside {4'hA, 4'hB, 4'hC}) imm = 2'b10;
            else                             imm = 2'b11;
            dirx = (op == 4'h6) && ins[0];
            uns  = (op == 4'hD);
            br   = op inside {4'hA, 4'hB};
            jp   = (op == 4'hC);
            wc   = {op == 4'h8, op == 4'h9, (op <= 4'h8) || (op == 4'hD), op == 4'h8};
        end
        mem_exp = (hist.size() >= 2) ? hist[hist.size()-2] : 4'b0000;
        wb_exp  = (hist.size() >= 3) ? hist[hist.size()-3][1] : 1'b0;

        check("opcode", 16'(opcode), 16'(op_exp));
        check("imm_src", 16'(ImmSrc), 16'(imm));
        check("id_ctl", 16'({ALUsrc, dir, is_unsigned, Branch, jump, PC_sel}),
              16'({alus, dirx, uns, br, jp, br | jp}));
        check("mem_ctl", 16'({MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM}), 16'(mem_exp));
        check("regwrite_wb", 16'(RegWrite_WB), 16'(wb_exp));
        check("state", 16'(state), 16'(es));
        check("halted", 16'(halted), 16'(es == 2));

        hist.push_back((active && !st) ? wc : 4'b0000);
        if (active && !st && op == 4'hF) halt_at = cyc;
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
    task automatic apply_reset();
        instruction_IF = NOP;
        stall          = 1'b0;
        flush          = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_state", 16'(state), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_mem", 16'({MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM}), 16'd0);
        check("rst_wb", 16'(RegWrite_WB), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        cyc     = 0;
        halt_at = -1;
        hist.delete();
    endtask

    initial begin
        logic [3:0] rop;
        reset          = 1'b1;
        instruction_IF = NOP;
        stall          = 1'b0;
        flush          = 1'b0;
        cyc            = 0;
        halt_at        = -1;
        @(negedge clk);

        // LW through MEM and WB
        apply_reset();
        step(16'h8123, 1'b0, 1'b0);
        repeat (4) step(NOP, 1'b0, 1'b0);

        // SW stalled, then retried
        apply_reset();
        step(16'h9ABC, 1'b1, 1'b0);
        step(16'h9ABC, 1'b0, 1'b0);
        repeat (4) step(NOP, 1'b0, 1'b0);

        // Branch decode, flushed branch, other immediates and SHIFT direction
        apply_reset();
        step(16'hA0F0, 1'b0, 1'b0);
        step(16'hA0F0, 1'b0, 1'b1);
        step(16'h6001, 1'b0, 1'b0);
        step(16'hD000, 1'b0, 1'b0);
        step(16'hC0FF, 1'b0, 1'b0);
        step(16'h7005, 1'b0, 1'b0);
        step(16'hB123, 1'b0, 1'b0);
        repeat (3) step(NOP, 1'b0, 1'b0);

        // HALT flushed or stalled stays in RUN
        apply_reset();
        step(16'hF000, 1'b0, 1'b1);
        step(16'hF000, 1'b1, 1'b0);
        repeat (3) step(NOP, 1'b0, 1'b0);

        // ADD then HALT: drain, halt, later instructions suppressed, async reset out of HALTED
        apply_reset();
        step(16'h0123, 1'b0, 1'b0);
        step(16'hF000, 1'b0, 1'b0);
        step(16'h1111, 1'b0, 1'b1);
        step(16'h8000, 1'b0, 1'b0);
        step(16'h2222, 1'b1, 1'b0);
        step(16'h0456, 1'b0, 1'b0);
        step(16'hA0F0, 1'b0, 1'b0);
        apply_reset();
        step(16'h0456, 1'b0, 1'b0);
        repeat (3) step(NOP, 1'b0, 1'b0);

        // Random streams
        for (int ep = 0; ep < 20; ep++) begin
            apply_reset();
            for (int i = 0; i < 40; i++) begin
                rop = 4'($urandom_range(0, 15));
                if (rop == 4'hF && $urandom_range(0, 2) != 0) rop = 4'h0;
                step({rop, 12'($urandom)}, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
